// File: rtl/oob_dev_ctrl.sv
// Device-side SATA OOB responder: COMRESET -> COMINIT, COMWAKE exchange, ALIGNp/SYNCp bring-up, then data pass-through.
// Latency: all outputs registered; txcominit/txcomwake pulse 1 cycle after state entry, tx data path 1 cycle in LINK_UP.
// No backpressure: fixed-rate stream; OOB_DEV_DEBUG_EN exposes {retry, sync_cnt, 2'b0, state} on debug.
module oob_dev_ctrl #(
    parameter int DATA_BYTE_WIDTH = 4,      // only 4 is supported
    parameter int CLK_SPEED_GRADE = 1,      // 1: 75 MHz, 2: 150 MHz, 4: 300 MHz
    parameter int COMWAKE_TMO     = 16384,
    parameter int ALIGN_TMO       = 65536,
    parameter int MAX_RETRY       = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         gtx_ready,
    input  logic                         rxcominitdet_in,
    input  logic                         rxcomwakedet_in,
    input  logic                         rxelecidle_in,
    input  logic                         txcomfinish_in,
    output logic                         txcominit,
    output logic                         txcomwake,
    output logic                         txelecidle,
    input  logic [DATA_BYTE_WIDTH*8-1:0] txdata_in,
    input  logic [DATA_BYTE_WIDTH-1:0]   txcharisk_in,
    output logic [DATA_BYTE_WIDTH*8-1:0] txdata_out,
    output logic [DATA_BYTE_WIDTH-1:0]   txcharisk_out,
    input  logic [DATA_BYTE_WIDTH*8-1:0] rxdata_in,
    input  logic [DATA_BYTE_WIDTH-1:0]   rxcharisk_in,
    input  logic                         rxbyteisaligned,
    output logic                         phy_ready,
    output logic                         link_down,
    output logic [11:0]                  debug
);

    localparam int DW = DATA_BYTE_WIDTH * 8;
    localparam int KW = DATA_BYTE_WIDTH;

    localparam logic [DW-1:0] ALIGNP  = DW'(32'h7B4A4ABC);
    localparam logic [DW-1:0] SYNCP   = DW'(32'hB5B5957C);
    localparam logic [KW-1:0] K_FIRST = KW'(1);

    // Timeout fires on the cycle the counter equals limit-1.
    localparam logic [19:0] CW_LAST = 20'(COMWAKE_TMO * CLK_SPEED_GRADE - 1);
    localparam logic [19:0] AL_LAST = 20'(ALIGN_TMO * CLK_SPEED_GRADE - 1);
    localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRY);

    typedef enum logic [3:0] {
        IDLE          = 4'd0,
        SEND_CI       = 4'd1,
        WAIT_CW       = 4'd2,
        SEND_CW       = 4'd3,
        WAIT_IDLE_END = 4'd4,
        SEND_ALIGN    = 4'd5,
        SEND_SYNC     = 4'd6,
        LINK_UP       = 4'd7
    } state_t;

    state_t      state, state_nxt;
    logic [19:0] timer;
    logic [3:0]  retry, retry_nxt, retry_inc;
    logic [1:0]  sync_cnt, sync_nxt;
    logic        miss_q;      // rxbyteisaligned was low last cycle in LINK_UP
    logic        idle_q;      // rxelecidle_in was high last cycle in LINK_UP
    logic        timeout;
    logic        link_drop;
    logic        rx_is_align;

    assign rx_is_align = (rxdata_in == ALIGNP) && (rxcharisk_in == K_FIRST);
    assign retry_inc   = (retry == 4'hF) ? retry : retry + 4'd1;

    // Next-state logic: handshake progression, timeouts with retry, COMRESET override last.
    always_comb begin
        state_nxt = state;
        retry_nxt = retry;
        sync_nxt  = 2'd0;
        timeout   = 1'b0;
        link_drop = 1'b0;
        case (state)
            IDLE: begin
                // retry is kept while idling so the debug view shows why we gave up
                if (rxcominitdet_in) begin
                    state_nxt = SEND_CI;
                    retry_nxt = 4'd0;
                end
            end
            SEND_CI: begin
                if (txcomfinish_in) state_nxt = WAIT_CW;
            end
            WAIT_CW: begin
                if (rxcomwakedet_in)       state_nxt = SEND_CW;
                else if (timer == CW_LAST) timeout   = 1'b1;
            end
            SEND_CW: begin
                if (txcomfinish_in) state_nxt = WAIT_IDLE_END;
            end
            WAIT_IDLE_END: begin
                if (!rxelecidle_in) state_nxt = SEND_ALIGN;
            end
            SEND_ALIGN: begin
                if (rxbyteisaligned && rx_is_align) state_nxt = SEND_SYNC;
                else if (timer == AL_LAST)          timeout   = 1'b1;
            end
            SEND_SYNC: begin
                if (rx_is_align) begin
                    sync_nxt = 2'd0;
                end else if (sync_cnt == 2'd2) begin
                    state_nxt = LINK_UP;
                    retry_nxt = 4'd0;
                end else begin
                    sync_nxt = sync_cnt + 2'd1;
                end
            end
            LINK_UP: begin
                if ((!rxbyteisaligned && miss_q) || (rxelecidle_in && idle_q)) begin
                    state_nxt = IDLE;
                    link_drop = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (timeout) begin
            retry_nxt = retry_inc;
            state_nxt = (retry_inc >= RETRY_LIMIT) ? IDLE : SEND_CI;
        end

        // A host COMRESET always restarts the handshake, even over a same-cycle timeout.
        if (rxcominitdet_in && state != IDLE && state != SEND_CI) begin
            state_nxt = SEND_CI;
            retry_nxt = retry;
            sync_nxt  = 2'd0;
            link_drop = (state == LINK_UP);
        end
    end

    // State, timer and counters; losing gtx_ready behaves like reset.
    always_ff @(posedge clk) begin
        if (rst || !gtx_ready) begin
            state    <= IDLE;
            timer    <= 20'd0;
            retry    <= 4'd0;
            sync_cnt <= 2'd0;
            miss_q   <= 1'b0;
            idle_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            if (state_nxt != state) timer <= 20'd0;
            else if (timer != '1)   timer <= timer + 20'd1;
            retry    <= retry_nxt;
            sync_cnt <= sync_nxt;
            miss_q   <= (state == LINK_UP) && (state_nxt == LINK_UP) && !rxbyteisaligned;
            idle_q   <= (state == LINK_UP) && (state_nxt == LINK_UP) && rxelecidle_in;
        end
    end

    // Registered outputs: OOB pulses on the first cycle of their state, tx mux by current state.
    always_ff @(posedge clk) begin
        if (rst || !gtx_ready) begin
            txcominit     <= 1'b0;
            txcomwake     <= 1'b0;
            txelecidle    <= 1'b1;
            txdata_out    <= '0;
            txcharisk_out <= '0;
            phy_ready     <= 1'b0;
            link_down     <= 1'b0;
        end else begin
            txcominit  <= (state == SEND_CI) && (timer == 20'd0);
            txcomwake  <= (state == SEND_CW) && (timer == 20'd0);
            // Follows the next state so the line leaves idle on the same edge we enter SEND_ALIGN.
            txelecidle <= !(state_nxt inside {SEND_ALIGN, SEND_SYNC, LINK_UP});
            phy_ready  <= (state_nxt == LINK_UP) && rxbyteisaligned;
            link_down  <= link_drop;
            case (state)
                SEND_ALIGN: begin
                    txdata_out    <= ALIGNP;
                    txcharisk_out <= K_FIRST;
                end
                SEND_SYNC: begin
                    txdata_out    <= SYNCP;
                    txcharisk_out <= K_FIRST;
                end
                LINK_UP: begin
                    txdata_out    <= txdata_in;
                    txcharisk_out <= txcharisk_in;
                end
                default: begin
                    txdata_out    <= '0;
                    txcharisk_out <= '0;
                end
            endcase
        end
    end

`ifdef OOB_DEV_DEBUG_EN
    assign debug = {retry, sync_cnt, 2'b00, state};
`else
    assign debug = 12'h000;
`endif

endmodule
